// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and data-memory wait
// freezing for a 4-stage pipe, with stall statistics and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ra1D,
    input  logic [3:0]  ra2D,
    input  logic [3:0]  wa3E,
    input  logic        regWriteE,
    input  logic        memToRegE,
    input  logic        branchTakenE,
    input  logic        memReqM,
    input  logic        memReadyM,
    output logic        enF,
    output logic        enFD,
    output logic        enDE,
    output logic        enEM,
    output logic        flushFD,
    output logic        flushDE,
    output logic [1:0]  state,
    output logic [15:0] stallCount,
    output logic        memTimeout
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [15:0]         r_stall_cnt;
    logic                r_timeout;

    logic w_load_use;
    logic w_mem_wait;
    logic w_en_f, w_en_fd, w_en_de, w_en_em;
    logic w_flush_fd, w_flush_de;

    // R15 is the PC, never a real load destination, so it cannot create a load-use hazard
    assign w_load_use = memToRegE & regWriteE & (wa3E != 4'd15) &
                        ((wa3E == ra1D) | (wa3E == ra2D));
    assign w_mem_wait = memReqM & ~memReadyM;

    // Next state, wait counter and raw enable/flush decode
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_en_f      = 1'b1;
        w_en_fd     = 1'b1;
        w_en_de     = 1'b1;
        w_en_em     = 1'b1;
        w_flush_fd  = 1'b0;
        w_flush_de  = 1'b0;

        case (r_state)
            RUN: begin
                if (w_mem_wait) begin
                    {w_en_f, w_en_fd, w_en_de, w_en_em} = 4'b0000;
                    w_state_nxt = MEMWAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end else if (branchTakenE) begin
                    w_flush_fd = 1'b1;
                    w_flush_de = 1'b1;
                end else if (w_load_use) begin
                    w_en_f      = 1'b0;
                    w_en_fd     = 1'b0;
                    w_flush_de  = 1'b1;
                    w_state_nxt = LDSTALL;
                end
            end
            LDSTALL: begin
                if (w_mem_wait) begin
                    {w_en_f, w_en_fd, w_en_de, w_en_em} = 4'b0000;
                    w_state_nxt = MEMWAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end else begin
                    w_state_nxt = RUN;
                end
            end
            MEMWAIT: begin
                if (!memReadyM) begin
                    {w_en_f, w_en_fd, w_en_de, w_en_em} = 4'b0000;
                    if (r_wait < WAIT_W'(TIMEOUT))
                        w_wait_nxt = r_wait + WAIT_W'(1);
                end else begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Reset forces a clean, non-stalling pipe regardless of the hazard inputs
    assign enF     = reset | w_en_f;
    assign enFD    = reset | w_en_fd;
    assign enDE    = reset | w_en_de;
    assign enEM    = reset | w_en_em;
    assign flushFD = ~reset & w_flush_fd;
    assign flushDE = ~reset & w_flush_de;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_wait      <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            if (!w_en_f && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_wait_nxt == WAIT_W'(TIMEOUT))
                r_timeout <= 1'b1;
        end
    end

    assign state      = r_state;
    assign stallCount = r_stall_cnt;
    assign memTimeout = r_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table walked from reset plus
// hand-written timeout and asynchronous-reset sequences.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ra1D, ra2D, wa3E;
    logic        regWriteE, memToRegE, branchTakenE, memReqM, memReadyM;
    logic        enF, enFD, enDE, enEM, flushFD, flushDE;
    logic [1:0]  state;
    logic [15:0] stallCount;
    logic        memTimeout;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .ra1D(ra1D), .ra2D(ra2D), .wa3E(wa3E),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .branchTakenE(branchTakenE),
        .memReqM(memReqM), .memReadyM(memReadyM),
        .enF(enF), .enFD(enFD), .enDE(enDE), .enEM(enEM),
        .flushFD(flushFD), .flushDE(flushDE),
        .state(state), .stallCount(stallCount), .memTimeout(memTimeout)
    );

    always #5 clk = ~clk;

    // {enF, enFD, enDE, enEM, flushFD, flushDE}
    localparam logic [5:0] CTL_DEF    = 6'b111100;
    localparam logic [5:0] CTL_FREEZE = 6'b000000;
    localparam logic [5:0] CTL_LDUSE  = 6'b001101;
    localparam logic [5:0] CTL_BRANCH = 6'b111111;

    typedef struct {
        logic [3:0]  ra1, ra2, wa3;
        logic        rw, m2r, br, req, rdy;
        logic [1:0]  st;
        logic [5:0]  ctl;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                                input logic rw, input logic m2r, input logic br,
                                input logic req, input logic rdy,
                                input logic [1:0] st, input logic [5:0] ctl, input logic [15:0] sc);
        vec_t v;
        v.ra1 = ra1; v.ra2 = ra2; v.wa3 = wa3;
        v.rw = rw; v.m2r = m2r; v.br = br; v.req = req; v.rdy = rdy;
        v.st = st; v.ctl = ctl; v.sc = sc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                         input logic rw, input logic m2r, input logic br,
                         input logic req, input logic rdy);
        ra1D = ra1; ra2D = ra2; wa3E = wa3;
        regWriteE = rw; memToRegE = m2r; branchTakenE = br;
        memReqM = req; memReadyM = rdy;
    endtask

    function automatic logic [5:0] ctl_now();
        return {enF, enFD, enDE, enEM, flushFD, flushDE};
    endfunction

    initial begin
        // Walk from reset; st/ctl/sc are what must be seen during each cycle, before its edge
        vecs[0]  = mk(4'd1, 4'd2, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, CTL_DEF,    16'd0);
        vecs[1]  = mk(4'd3, 4'd0, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, CTL_LDUSE,  16'd0);
        vecs[2]  = mk(4'd3, 4'd0, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, CTL_DEF,    16'd1);
        vecs[3]  = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, CTL_DEF,    16'd1);
        vecs[4]  = mk(4'd0, 4'd15, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, CTL_DEF,   16'd1);
        vecs[5]  = mk(4'd3, 4'd0, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, CTL_BRANCH, 16'd1);
        vecs[6]  = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, CTL_DEF,    16'd1);
        vecs[7]  = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, CTL_FREEZE, 16'd1);
        vecs[8]  = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, CTL_FREEZE, 16'd2);
        vecs[9]  = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, CTL_FREEZE, 16'd3);
        vecs[10] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, CTL_FREEZE, 16'd4);
        vecs[11] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, CTL_DEF,    16'd5);
        vecs[12] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, CTL_DEF,    16'd5);
        vecs[13] = mk(4'd7, 4'd6, 4'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, CTL_LDUSE,  16'd5);
        vecs[14] = mk(4'd7, 4'd6, 4'd6,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, CTL_FREEZE, 16'd6);
        vecs[15] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, CTL_DEF,    16'd7);
        vecs[16] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, CTL_DEF,    16'd7);
        vecs[17] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, CTL_FREEZE, 16'd7);
        vecs[18] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, CTL_DEF,    16'd8);
        vecs[19] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, CTL_BRANCH, 16'd8);
        vecs[20] = mk(4'd0, 4'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, CTL_DEF,    16'd8);

        reset = 1'b1;
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_stallcount", 32'(stallCount), 32'd0);
        chk("reset_timeout", 32'(memTimeout), 32'd0);
        // Hazard inputs must not leak through while reset is held
        drive(4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("reset_ctl_masked", 32'(ctl_now()), 32'(CTL_DEF));

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 21; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].ra1, vecs[i].ra2, vecs[i].wa3, vecs[i].rw, vecs[i].m2r,
                  vecs[i].br, vecs[i].req, vecs[i].rdy);
            #2;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_stallcount", i), 32'(stallCount), 32'(vecs[i].sc));
            chk($sformatf("vec%0d_timeout", i), 32'(memTimeout), 32'd0);
        end

        // Timeout: wait counter reaches 8 on the 8th wait edge
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            #2;
            chk($sformatf("to_wait%0d_flag", e), 32'(memTimeout), (e >= 8) ? 32'd1 : 32'd0);
            chk($sformatf("to_wait%0d_ctl", e), 32'(ctl_now()), 32'(CTL_FREEZE));
        end
        @(negedge clk);
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("to_ready_state", 32'(state), 32'd2);
        chk("to_ready_ctl", 32'(ctl_now()), 32'(CTL_DEF));
        chk("to_ready_stallcount", 32'(stallCount), 32'd18);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #2;
            chk($sformatf("to_sticky%0d", k), 32'(memTimeout), 32'd1);
            chk($sformatf("to_after%0d_state", k), 32'(state), 32'd0);
        end

        // Asynchronous reset in the middle of a memory wait
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        #2;
        chk("mw_before_rst_state", 32'(state), 32'd2);
        chk("mw_before_rst_ctl", 32'(ctl_now()), 32'(CTL_FREEZE));
        reset = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_ctl", 32'(ctl_now()), 32'(CTL_DEF));
        chk("async_rst_stallcount", 32'(stallCount), 32'd0);
        chk("async_rst_timeout", 32'(memTimeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #2;
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_ctl", 32'(ctl_now()), 32'(CTL_DEF));
        chk("post_rst_stallcount", 32'(stallCount), 32'd0);

        // Reset mid-LDSTALL leaves no residual stall
        @(negedge clk);
        drive(4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #2;
        chk("ld_before_rst_state", 32'(state), 32'd1);
        reset = 1'b1;
        #1;
        chk("ld_rst_state", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("ld_post_rst_ctl", 32'(ctl_now()), 32'(CTL_DEF));
        @(negedge clk); #2;
        chk("ld_post_rst_state", 32'(state), 32'd0);
        chk("ld_post_rst_stallcount", 32'(stallCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
